pixel_index_decoder: RTL and testbench
======================================

# pixel_index_decoder

Consumer-side decoder for the linear pixel index stream used by the VGA compatibility test. It accepts a linear framebuffer index (0 .. X_RES*Y_RES-1) plus a colour, then converts the index to (x, y) with a bit-serial restoring division by X_RES. The result is presented to the VGA adapter plot interface through a valid/ready handshake. It sits between any index-stream producer (sweep counters, fill engines) and the adapter's x/y/colour/plot inputs.

## Interface
- X_RES, 320, horizontal resolution; also the divisor.
- Y_RES, 240, vertical resolution; indices at or above X_RES*Y_RES are out of range.
- IDX_W, 17, index width; equals the shared `X_Y_PRODUCT_BITES` width.
- X_W, 9, x coordinate width.
- Y_W, 8, y coordinate width.
- COLOUR_W, 3, colour width.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer has an index.
- in_ready  out  1  equals (state==IDLE) && resetn.
- in_index  in  IDX_W  linear pixel index.
- in_colour  in  COLOUR_W  pixel colour.
- out_valid  out  1  decoded pixel available (drives adapter plot when qualified by out_ready).
- out_ready  in  1  adapter accepts the pixel.
- out_x  out  X_W  index mod X_RES.
- out_y  out  Y_W  index div X_RES.
- out_colour  out  COLOUR_W  captured colour.
- err  out  1  one-cycle pulse when an out-of-range index is accepted.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, DIVIDE, DONE.
- **IDLE:**
  - A transfer occurs when in_valid && in_ready.
  - If in_index >= X_RES*Y_RES: register err=1 for one cycle, stay in IDLE, discard the pixel, and never assert out_valid for it.
  - Otherwise: capture the index into the dividend shift register and capture the colour. Clear the remainder and step counter, then go to DIVIDE.
- **DIVIDE:**
  - Performs one restoring step per cycle, MSB first: rem = {rem, dividend_msb}; if rem >= X_RES then rem -= X_RES and shift in quotient bit 1, else shift in 0.
  - The remainder register is X_W+1 bits wide.
  - After IDX_W steps, go to DONE with out_valid=1.
- **DONE:**
  - out_x = remainder[X_W-1:0]; out_y = quotient[Y_W-1:0]. The range check guarantees the quotient is < Y_RES.
  - out_x, out_y and out_colour hold stable while out_valid && !out_ready.
  - On out_valid && out_ready: clear out_valid and go to IDLE.
- in_valid, in_index and in_colour are ignored outside IDLE.
- All outputs are registered, except in_ready and busy, which decode from state.

## Timing
- Reset (resetn low, asynchronous) forces:
  - state=IDLE, out_valid=0, out_x=0, out_y=0, out_colour=0, err=0, busy=0.
  - in_ready=0 while resetn is low, and 1 from the first cycle after release.
- Reset mid-DIVIDE or mid-DONE aborts the pixel; nothing is plotted.
- Latency: accept at edge A; out_valid is high after edge A+IDX_W (A+17 at defaults).
- Throughput with out_ready tied high: the DONE handshake completes at A+18, IDLE is entered, and the next accept is at A+19. That is one pixel per 19 cycles.
- err rises on the accept edge and falls on the next edge. in_ready stays 1, so back-to-back bad indices each pulse err.
- out_ready may be high before out_valid; the handshake then completes on the first DONE edge.
- Boundaries:
  - index 0 decodes to (0,0).
  - index X_RES-1 decodes to (X_RES-1, 0).
  - index X_RES decodes to (0, 1).
  - index X_RES*Y_RES-1 decodes to (X_RES-1, Y_RES-1).
  - index X_RES*Y_RES raises err.

## Structure
- The shared definitions header holds `X_Y_PRODUCT_BITES`, the X_RES/Y_RES defaults and the coordinate widths, shared with the index producers.
- State encoding is a localparam inside the module.
- One sub-module, `index_divider`, holds the bit-serial restoring divider. It is parameterised on dividend width and constant divisor, with start/done/quotient/remainder ports.
- The top level owns the handshake, range check and colour capture.

## Test plan
- index 0, colour 3'b101 -> after 17 cycles out_valid=1, out_x=0, out_y=0, out_colour=3'b101; err stays 0.
- index 319, then index 320 -> (319,0) then (0,1); with out_ready high, the second accept occurs exactly 19 cycles after the first.
- index 76799 -> out_x=319, out_y=239.
- index 76800 and 131071 back-to-back -> two one-cycle err pulses, out_valid never asserts, in_ready stays 1.
- index 1000, out_ready low for 5 cycles after out_valid -> out_x=40, out_y=3 held stable; in_ready=0 and in_valid is ignored; handshake on the sixth edge returns to IDLE.
- resetn pulsed low 8 cycles into DIVIDE -> out_valid=0 and busy=0 immediately; a following index 641 decodes to (1,2).

Source files
------------

// File: rtl/pixel_index_decoder_pkg.sv
// Shared definitions for the linear pixel index stream.
// Index producers (sweep counters, fill engines) and the decoder import this
// package so that resolution and coordinate widths stay consistent.
//   X_Y_PRODUCT_BITES : width of a linear index covering X_RES*Y_RES pixels
//   X_RES_DEF/Y_RES_DEF : default screen resolution
//   X_W_DEF/Y_W_DEF/COLOUR_W_DEF : coordinate and colour widths
package pixel_index_decoder_pkg;

    localparam int X_Y_PRODUCT_BITES = 17;
    localparam int X_RES_DEF         = 320;
    localparam int Y_RES_DEF         = 240;
    localparam int X_W_DEF           = 9;
    localparam int Y_W_DEF           = 8;
    localparam int COLOUR_W_DEF      = 3;

    // Number of addressable pixels; indices at or above this are invalid.
    function automatic int pixel_count(input int xr, input int yr);
        return xr * yr;
    endfunction

endpackage

// File: rtl/index_divider.sv
// Bit-serial restoring divider by a constant.
// One quotient bit per cycle, MSB first. The dividend register is shifted
// left in place and receives the quotient bits at its LSB, so after DW steps
// it holds the quotient.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start_i         : load dividend_i, clear remainder and step counter
//   dividend_i      : value to divide
//   done_o          : high during the cycle whose edge performs the last step
//   quotient_o      : quotient (valid once the last step has completed)
//   remainder_o     : remainder (valid once the last step has completed)
module index_divider #(
    parameter int DW      = 17,
    parameter int RW      = 10,
    parameter int DIVISOR = 320
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [DW-1:0] dividend_i,
    output logic          done_o,
    output logic [DW-1:0] quotient_o,
    output logic [RW-1:0] remainder_o
);

    localparam int CW = $clog2(DW + 1);

    logic [DW-1:0] dq_q;
    logic [RW-1:0] rem_q;
    logic [CW-1:0] cnt_q;
    logic          run_q;

    logic [RW-1:0] rem_sh;
    logic          ge;
    logic [RW-1:0] rem_d;

    // rem < DIVISOR before the shift, so 2*rem+1 fits in RW bits.
    assign rem_sh = {rem_q[RW-2:0], dq_q[DW-1]};
    assign ge     = rem_sh >= RW'(DIVISOR);
    assign rem_d  = ge ? rem_sh - RW'(DIVISOR) : rem_sh;
    assign done_o = run_q && (cnt_q == CW'(DW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq_q  <= '0;
            rem_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            dq_q  <= dividend_i;
            rem_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            dq_q  <= {dq_q[DW-2:0], ge};
            rem_q <= rem_d;
            cnt_q <= cnt_q + 1'b1;
            if (done_o) run_q <= 1'b0;
        end
    end

    assign quotient_o  = dq_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/pixel_index_decoder.sv
// Linear pixel index -> (x, y) decoder for the VGA adapter plot interface.
// Accepts an index and colour in IDLE, range-checks it, divides by X_RES
// bit-serially and presents the result on a valid/ready handshake.
//   clk, resetn           : clock, asynchronous active-low reset
//   in_valid/in_ready     : index stream handshake (in_ready only in IDLE)
//   in_index, in_colour   : linear pixel index and its colour
//   out_valid/out_ready   : decoded pixel handshake towards the adapter
//   out_x, out_y          : index mod X_RES, index div X_RES
//   out_colour            : colour captured with the index
//   err                   : one-cycle pulse for an accepted out-of-range index
//   busy                  : decoder is not idle
module pixel_index_decoder
    import pixel_index_decoder_pkg::*;
#(
    parameter int X_RES    = X_RES_DEF,
    parameter int Y_RES    = Y_RES_DEF,
    parameter int IDX_W    = X_Y_PRODUCT_BITES,
    parameter int X_W      = X_W_DEF,
    parameter int Y_W      = Y_W_DEF,
    parameter int COLOUR_W = COLOUR_W_DEF
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IDX_W-1:0]    in_index,
    input  logic [COLOUR_W-1:0] in_colour,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [X_W-1:0]      out_x,
    output logic [Y_W-1:0]      out_y,
    output logic [COLOUR_W-1:0] out_colour,
    output logic                err,
    output logic                busy
);

    localparam int PIXELS = pixel_count(X_RES, Y_RES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              state_q;
    logic                out_valid_q;
    logic [COLOUR_W-1:0] colour_q;
    logic                err_q;

    logic                accept;
    logic                in_range;
    logic                div_start;
    logic                div_done;
    logic [IDX_W-1:0]    quot;
    logic [X_W:0]        rem;

    assign in_ready  = (state_q == S_IDLE) && resetn;
    assign busy      = (state_q != S_IDLE);
    assign accept    = in_valid && in_ready;
    assign in_range  = in_index < IDX_W'(PIXELS);
    assign div_start = accept && in_range;

    index_divider #(
        .DW      (IDX_W),
        .RW      (X_W + 1),
        .DIVISOR (X_RES)
    ) u_div (
        .clk         (clk),
        .rst_n       (resetn),
        .start_i     (div_start),
        .dividend_i  (in_index),
        .done_o      (div_done),
        .quotient_o  (quot),
        .remainder_o (rem)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            colour_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept && !in_range) begin
                        err_q <= 1'b1;
                    end else if (div_start) begin
                        colour_q <= in_colour;
                        state_q  <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    if (div_done) begin
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Divider registers stop updating after the last step, so the result
    // holds while the adapter stalls. The range check keeps the quotient
    // below Y_RES, so its upper bits are always zero.
    assign out_valid  = out_valid_q;
    assign out_x      = rem[X_W-1:0];
    assign out_y      = quot[Y_W-1:0];
    assign out_colour = colour_q;
    assign err        = err_q;

    logic unused_bits;
    assign unused_bits = ^{quot[IDX_W-1:Y_W], rem[X_W]};

endmodule

// File: tb/tb_pixel_index_decoder.sv
module tb_pixel_index_decoder;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] in_index;
    logic [2:0]  in_colour;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_x;
    logic [7:0]  out_y;
    logic [2:0]  out_colour;
    logic        err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int acc_cnt = 0;
    int acc_cyc = 0;

    pixel_index_decoder dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_index   (in_index),
        .in_colour  (in_colour),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_colour (out_colour),
        .err        (err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && in_ready) begin
            acc_cnt <= acc_cnt + 1;
            acc_cyc <= cyc;
        end
    end

    typedef struct {
        int       idx;
        int       col;
        bit       bad;
        int       x;
        int       y;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply one index with out_ready low, check err or latency/result, then
    // complete the handshake.
    task automatic run_px(input int idx, input int col, input bit bad,
                          input int x, input int y, input string name);
        int n;
        @(negedge clk);
        in_valid  = 1'b1;
        in_index  = 17'(idx);
        in_colour = 3'(col);
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk({name, " ready_timeout"}, 0, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (bad) begin
            chk({name, " err_pulse"}, int'(err), 1);
            chk({name, " no_valid"}, int'(out_valid), 0);
            @(negedge clk);
            chk({name, " err_fall"}, int'(err), 0);
        end else begin
            chk({name, " no_err"}, int'(err), 0);
            n = 0;
            while (!out_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk({name, " latency"}, n, 17);
            chk({name, " x"}, int'(out_x), x);
            chk({name, " y"}, int'(out_y), y);
            chk({name, " colour"}, int'(out_colour), col);
            out_ready = 1'b1;
            @(negedge clk);
            chk({name, " valid_clr"}, int'(out_valid), 0);
            chk({name, " idle"}, int'(busy), 0);
            out_ready = 1'b0;
        end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk({name, " valid_timeout"}, 0, 1);
    endtask

    initial begin
        int t0, t1, c0, n, seen;

        vecs[0] = '{0,     5, 1'b0, 0,   0};
        vecs[1] = '{319,   1, 1'b0, 319, 0};
        vecs[2] = '{320,   2, 1'b0, 0,   1};
        vecs[3] = '{76799, 7, 1'b0, 319, 239};
        vecs[4] = '{1000,  4, 1'b0, 40,  3};
        vecs[5] = '{12345, 3, 1'b0, 185, 38};
        vecs[6] = '{63999, 6, 1'b0, 319, 199};
        vecs[7] = '{76800, 1, 1'b1, 0,   0};
        vecs[8] = '{131071,2, 1'b1, 0,   0};
        vecs[9] = '{641,   0, 1'b0, 1,   2};

        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_index  = '0;
        in_colour = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst in_ready", int'(in_ready), 0);
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst out_x", int'(out_x), 0);
        chk("rst out_y", int'(out_y), 0);
        chk("rst colour", int'(out_colour), 0);
        chk("rst err", int'(err), 0);
        chk("rst busy", int'(busy), 0);
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst in_ready", int'(in_ready), 1);

        for (int i = 0; i < 10; i++)
            run_px(vecs[i].idx, vecs[i].col, vecs[i].bad, vecs[i].x, vecs[i].y,
                   $sformatf("vec%0d", i));

        // Throughput with out_ready tied high: accepts 19 cycles apart.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_index  = 17'd319;
        in_colour = 3'd1;
        c0 = acc_cnt;
        n = 0;
        while (acc_cnt != c0 + 1 && n < 40) begin @(negedge clk); n++; end
        t0 = acc_cyc;
        in_index = 17'd320;
        wait_valid("tp1");
        chk("tp1 x", int'(out_x), 319);
        chk("tp1 y", int'(out_y), 0);
        n = 0;
        while (acc_cnt != c0 + 2 && n < 40) begin @(negedge clk); n++; end
        t1 = acc_cyc;
        in_valid = 1'b0;
        chk("tp accepts", acc_cnt - c0, 2);
        chk("tp spacing", t1 - t0, 19);
        wait_valid("tp2");
        chk("tp2 x", int'(out_x), 0);
        chk("tp2 y", int'(out_y), 1);
        @(negedge clk);
        chk("tp2 valid_clr", int'(out_valid), 0);
        out_ready = 1'b0;

        // Back-to-back out-of-range indices.
        @(negedge clk);
        in_valid = 1'b1;
        in_index = 17'd76800;
        @(negedge clk);
        chk("bad1 err", int'(err), 1);
        chk("bad1 in_ready", int'(in_ready), 1);
        in_index = 17'd131071;
        @(negedge clk);
        chk("bad2 err", int'(err), 1);
        chk("bad2 in_ready", int'(in_ready), 1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bad err_fall", int'(err), 0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1;
        end
        chk("bad never_valid", seen, 0);

        // Adapter stall: result held, new input ignored, handshake on 6th edge.
        @(negedge clk);
        in_valid  = 1'b1;
        in_index  = 17'd1000;
        in_colour = 3'd6;
        @(negedge clk);
        in_index = 17'd5;
        wait_valid("hold");
        c0 = acc_cnt;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("hold%0d valid", k), int'(out_valid), 1);
            chk($sformatf("hold%0d x", k), int'(out_x), 40);
            chk($sformatf("hold%0d y", k), int'(out_y), 3);
            chk($sformatf("hold%0d in_ready", k), int'(in_ready), 0);
        end
        chk("hold colour", int'(out_colour), 6);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("hold release valid", int'(out_valid), 0);
        chk("hold release in_ready", int'(in_ready), 1);
        chk("hold no_accept", acc_cnt - c0, 0);
        out_ready = 1'b0;

        // Reset 8 cycles into DIVIDE aborts the pixel.
        @(negedge clk);
        in_valid = 1'b1;
        in_index = 17'd5000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("abort busy", int'(busy), 0);
        chk("abort out_valid", int'(out_valid), 0);
        chk("abort in_ready", int'(in_ready), 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1;
        end
        chk("abort nothing_plotted", seen, 0);
        run_px(641, 3, 1'b0, 1, 2, "after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
